frame_streamer: RTL and testbench

- Downstream consumer of the down-sampling stage.
- Once the shrunk image is complete in the output pixel memory, this block reads it back in raster order from a synchronous-read RAM.
- It emits the pixels as a valid/ready stream with end-of-line and end-of-frame markers, for the display, UART or file-dump path.
- Sustains one pixel per clock under no backpressure and loses nothing under backpressure.

---
 rtl/frame_streamer.sv | 157 +++++++++++++++
 tb/tb_frame_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// Reads a finished frame from a synchronous-read pixel RAM in raster order and
// streams it out with eol/eof markers. Optional macro: FRAME_STREAMER_GRAY_EN.
module frame_streamer #(
    parameter int BPP    = 3,
    parameter int WIDTH  = 15,
    parameter int HEIGHT = 15,
    parameter int PIXELS = WIDTH * HEIGHT,
    localparam int AW    = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int DW    = 8 * BPP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_adrr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_eol,
    output logic          m_eof,
    output logic          busy,
    output logic          done,
    output logic [1:0]    o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW:0]     r_issued;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_inflight;
    logic            r_infl_eol;
    logic            r_infl_eof;
    logic [DW-1:0]   r_fifo_data [2];
    logic            r_fifo_eol  [2];
    logic            r_fifo_eof  [2];
    logic [1:0]      r_count;
    logic            r_rd_ptr;
    logic            r_wr_ptr;

    logic            w_pop;
    logic            w_rd_en;
    logic            w_issue_left;
    logic            w_iss_eol;
    logic            w_iss_eof;
    logic [1:0]      w_occ;
    logic [1:0]      w_count_nxt;
    logic            w_done;
    logic [DW-1:0]   w_cap_data;

    // Optional luma conversion on the capture path; no extra pipeline stage.
`ifdef FRAME_STREAMER_GRAY_EN
    generate
        if (BPP == 3) begin : g_gray
            logic [9:0] w_sum;
            logic [7:0] w_y;
            assign w_sum = {2'b00, rd_data[23:16]} + {1'b0, rd_data[15:8], 1'b0}
                         + {2'b00, rd_data[7:0]};
            assign w_y = 8'(w_sum >> 2);
            assign w_cap_data = {w_y, w_y, w_y};
        end else begin : g_pass
            assign w_cap_data = rd_data;
        end
    endgenerate
`else
    assign w_cap_data = rd_data;
`endif

    always_comb begin
        w_pop        = (r_count != 2'd0) && m_ready;
        w_issue_left = r_issued < (AW+1)'(PIXELS);
        w_iss_eol    = r_col == CW'(WIDTH - 1);
        w_iss_eof    = w_iss_eol && (r_row == RW'(HEIGHT - 1));
        // Occupancy after this cycle's pop, counting the read already in flight.
        w_occ        = r_count + 2'(r_inflight) - 2'(w_pop);
        w_count_nxt  = r_count + 2'(r_inflight) - 2'(w_pop);
        w_rd_en      = (r_state == S_STREAM) && w_issue_left && (w_occ < 2'd2);
        w_done       = (r_state == S_DRAIN) && w_pop && r_fifo_eof[r_rd_ptr];

        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_STREAM;
            S_STREAM: if (w_rd_en && (r_issued == (AW+1)'(PIXELS - 1))) w_next_state = S_DRAIN;
            S_DRAIN:  if (w_done) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_issued   <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_inflight <= 1'b0;
            r_infl_eol <= 1'b0;
            r_infl_eof <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_eol[i]  <= 1'b0;
                r_fifo_eof[i]  <= 1'b0;
            end
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && start) begin
                r_issued <= '0;
                r_col    <= '0;
                r_row    <= '0;
            end else if (w_rd_en) begin
                r_issued <= r_issued + (AW+1)'(1);
                if (w_iss_eol) begin
                    r_col <= '0;
                    r_row <= w_iss_eof ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            r_inflight <= w_rd_en;
            r_infl_eol <= w_rd_en & w_iss_eol;
            r_infl_eof <= w_rd_en & w_iss_eof;
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= w_cap_data;
                r_fifo_eol[r_wr_ptr]  <= r_infl_eol;
                r_fifo_eof[r_wr_ptr]  <= r_infl_eof;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_nxt;
        end
    end

    // Stream: a pixel transfers on a rising edge where m_valid and m_ready are both
    // high; while m_valid is high and m_ready low, data/eol/eof are held unchanged.
    assign m_valid     = r_count != 2'd0;
    assign m_data      = r_fifo_data[r_rd_ptr];
    assign m_eol       = r_fifo_eol[r_rd_ptr];
    assign m_eof       = r_fifo_eof[r_rd_ptr];
    assign rd_en       = w_rd_en;
    assign rd_adrr     = w_issue_left ? r_issued[AW-1:0] : AW'(PIXELS - 1);
    assign busy        = r_state != S_IDLE;
    assign done        = w_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer (4x2 frame): cycle table for the first
// frame, a queue-based frame model, hand sequences and randomized backpressure.
module tb_frame_streamer;

    localparam int BPP = 3;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int P   = W * H;
    localparam int AW  = 3;
    localparam int DW  = 8 * BPP;

    logic          clk;
    logic          rst;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_adrr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    frame_streamer #(.BPP(BPP), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_adrr(rd_adrr),
        .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .done(done), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- pixel memory (sync read, junk when not read) ----------------
    logic [DW-1:0] mem [P];
    initial rd_data = '0;
    always @(posedge clk) rd_data <= rd_en ? mem[rd_adrr] : DW'($urandom);

    // ---------------- scoreboard state ----------------
    logic [DW+1:0] exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic busy_exp = 1'b0;
    int  rd_cnt   = 0;
    int  rd_total = 0;
    int  hs_total = 0;
    int  hs_frame = 0;
    logic prev_stall = 1'b0;
    logic [DW+1:0] prev_val = '0;

    function automatic logic [DW-1:0] exp_pix(input logic [DW-1:0] x);
`ifdef FRAME_STREAMER_GRAY_EN
        logic [9:0] y;
        y = ({2'b00, x[23:16]} + 2 * {2'b00, x[15:8]} + {2'b00, x[7:0]}) / 4;
        return {y[7:0], y[7:0], y[7:0]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < P; i++)
            exp_q.push_back({(i == P - 1), ((i % W) == W - 1), exp_pix(mem[i])});
    endtask

    // Per-cycle checks plus the frame-level model update.
    task automatic monitor();
        logic hs;
        logic eof_hs;
        logic [DW+1:0] e;
        hs = m_valid && m_ready;
        eof_hs = 1'b0;
        chk("busy", 32'(busy), 32'(busy_exp));
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_hold", 32'({m_eof, m_eol, m_data}), 32'(prev_val));
        end
        if (!busy_exp) chk("rd_en_idle", 32'(rd_en), 0);
        if (rd_en) begin
            chk("rd_adrr", 32'(rd_adrr), rd_cnt);
            chk("rd_in_frame", 32'(busy_exp && rd_cnt < P), 1);
            rd_cnt++;
            rd_total++;
        end
        if (hs) begin
            hs_total++;
            hs_frame++;
            chk("hs_has_exp", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pixel", 32'({m_eof, m_eol, m_data}), 32'(e));
                eof_hs = e[DW+1];
            end
        end
        chk("done", 32'(done), 32'(eof_hs));
        chk("outstanding", 32'((rd_total - hs_total) <= 2), 1);
        prev_stall = m_valid && !m_ready;
        prev_val   = {m_eof, m_eol, m_data};
        if (!busy_exp) begin
            if (start) begin
                busy_exp = 1'b1;
                rd_cnt = 0;
                push_frame();
            end
        end else if (eof_hs) begin
            busy_exp = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic r);
        @(negedge clk);
        start   = s;
        m_ready = r;
        #1;
        monitor();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        busy_exp = 1'b0;
        rd_cnt = 0;
        rd_total = 0;
        hs_total = 0;
        prev_stall = 1'b0;
        #1;
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random with pct% ready
    task automatic run_until_idle(input int mode, input int pct);
        int g;
        logic r;
        g = 1;
        while (busy_exp && g < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((g % 4) == 0) || ((g % 4) == 3);
                default: r = ($urandom_range(0, 99) < pct);
            endcase
            step(1'b0, r);
            g++;
        end
        chk("frame_end", 32'(busy_exp), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- cycle table for the first frame ----------------
    typedef struct {
        logic          start;
        logic          ready;
        logic          e_rd_en;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        int            e_idx;
        logic          e_eol;
        logic          e_eof;
        logic          e_done;
        logic          e_busy;
    } vec_t;
    vec_t tbl [12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        int g;
        int rd0;
        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < P; i++) mem[i] = DW'(i);

        for (int c = 0; c < 12; c++) begin
            tbl[c].start   = (c == 0);
            tbl[c].ready   = 1'b1;
            tbl[c].e_rd_en = (c >= 1) && (c <= P);
            tbl[c].e_addr  = (c == 0) ? '0 : ((c <= P) ? AW'(c - 1) : AW'(P - 1));
            tbl[c].e_valid = (c >= 3) && (c <= P + 2);
            tbl[c].e_idx   = c - 3;
            tbl[c].e_eol   = tbl[c].e_valid && (((c - 3) % W) == W - 1);
            tbl[c].e_eof   = tbl[c].e_valid && ((c - 3) == P - 1);
            tbl[c].e_done  = (c == P + 2);
            tbl[c].e_busy  = (c >= 1) && (c <= P + 2);
        end

        // reset state
        do_reset(3);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_adrr", 32'(rd_adrr), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_eol", 32'(m_eol), 0);
        chk("rst_m_eof", 32'(m_eof), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);

        // first frame, cycle by cycle, ready held high
        for (int c = 0; c < 12; c++) begin
            step(tbl[c].start, tbl[c].ready);
            chk("tbl_rd_en", 32'(rd_en), 32'(tbl[c].e_rd_en));
            if (tbl[c].e_rd_en) chk("tbl_rd_adrr", 32'(rd_adrr), 32'(tbl[c].e_addr));
            chk("tbl_m_valid", 32'(m_valid), 32'(tbl[c].e_valid));
            if (tbl[c].e_valid) begin
                chk("tbl_m_data", 32'(m_data), 32'(exp_pix(mem[tbl[c].e_idx])));
                chk("tbl_m_eol", 32'(m_eol), 32'(tbl[c].e_eol));
                chk("tbl_m_eof", 32'(m_eof), 32'(tbl[c].e_eof));
            end
            chk("tbl_done", 32'(done), 32'(tbl[c].e_done));
            chk("tbl_busy", 32'(busy), 32'(tbl[c].e_busy));
        end

        // ready toggling 1,0,0,1
        hs_frame = 0;
        step(1'b1, 1'b1);
        run_until_idle(1, 0);
        chk("toggle_hs_count", hs_frame, P);

        // ready low for 20 cycles after start
        hs_frame = 0;
        rd0 = rd_total;
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        chk("stall_rd_pulses", rd_total - rd0, 2);
        chk("stall_m_valid", 32'(m_valid), 1);
        chk("stall_m_data", 32'(m_data), 32'(exp_pix(mem[0])));
        run_until_idle(0, 0);
        chk("stall_hs_count", hs_frame, P);

        // start at pixel 4 ignored; start in done cycle ignored; next IDLE cycle accepted
        hs_frame = 0;
        step(1'b1, 1'b1);
        g = 0;
        while (hs_frame < 4 && g < 50) begin
            step(1'b0, 1'b1);
            g++;
        end
        chk("reach_px4", 32'(hs_frame >= 4), 1);
        step(1'b1, 1'b1);
        g = 0;
        while (!done && g < 50) begin
            step(1'b0, 1'b1);
            g++;
        end
        chk("saw_done", 32'(done), 1);
        start = 1'b1;
        step(1'b1, 1'b1);
        chk("restart_busy_model", 32'(busy_exp), 1);
        run_until_idle(0, 0);
        chk("two_frames_hs", hs_frame, 2 * P);

        // reset on the cycle after the pixel-2 handshake
        hs_frame = 0;
        step(1'b1, 1'b1);
        g = 0;
        while (hs_frame < 3 && g < 50) begin
            step(1'b0, 1'b1);
            g++;
        end
        do_reset(1);
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rd_adrr", 32'(rd_adrr), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_rd_en", 32'(rd_en), 0);
        hs_frame = 0;
        step(1'b1, 1'b1);
        run_until_idle(2, 60);
        chk("post_rst_hs", hs_frame, P);

        // known colour pixel then random frames with random backpressure
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < P; i++) mem[i] = DW'($urandom);
            if (f == 0) mem[0] = 24'h4080C0;
            hs_frame = 0;
            step(1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b0);
            if (f == 0) begin
                chk("color_valid", 32'(m_valid), 1);
`ifdef FRAME_STREAMER_GRAY_EN
                chk("color_gray", 32'(m_data), 32'h808080);
`else
                chk("color_pass", 32'(m_data), 32'h4080C0);
`endif
            end
            run_until_idle(2, $urandom_range(20, 90));
            chk("rand_hs", hs_frame, P);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
